// File: rtl/kernel_stage0_mul_sched.sv
// Round-robin scheduler sharing one pipelined unsigned multiplier between N_REQ requesters.
// A {vld, id} shadow pipeline tags each product with the requester that issued it.
module kernel_stage0_mul_sched #(
    parameter int N_REQ       = 4,
    parameter int ID_W        = 2,
    parameter int A_W         = 5,
    parameter int B_W         = 14,
    parameter int P_W         = 19,
    parameter int MUL_LATENCY = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*A_W-1:0] req_a,
    input  logic [N_REQ*B_W-1:0] req_b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [ID_W-1:0]      res_id,
    output logic [P_W-1:0]       res_data,
    output logic                 mul_ce,
    output logic [A_W-1:0]       mul_din0,
    output logic [B_W-1:0]       mul_din1,
    input  logic [P_W-1:0]       mul_dout,
    output logic                 busy
);

    logic [ID_W-1:0]        ptr;
    logic [ID_W-1:0]        ptr_next;
    logic [ID_W-1:0]        grant_id;
    logic [N_REQ-1:0]       masked;
    logic                   found;
    logic                   issue;
    logic [MUL_LATENCY-1:0] vld_pipe;
    logic [ID_W-1:0]        id_pipe [MUL_LATENCY];

    assign res_valid = vld_pipe[MUL_LATENCY-1];
    assign res_id    = id_pipe[MUL_LATENCY-1];
    assign res_data  = mul_dout;
    assign busy      = |vld_pipe;
    assign mul_ce    = !(res_valid && !res_ready);

    always_comb begin
        masked   = '0;
        found    = 1'b0;
        grant_id = '0;
        for (int i = 0; i < N_REQ; i++) begin
            masked[i] = req_valid[i] && (ID_W'(i) >= ptr);
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                found    = 1'b1;
                grant_id = ID_W'(i);
            end
        end
        // Requesters at or after ptr win over the ones reached by wrapping around.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (masked[i]) begin
                grant_id = ID_W'(i);
            end
        end
    end

    assign issue     = found && mul_ce && !reset;
    assign req_ready = issue ? (N_REQ'(1) << grant_id) : '0;
    assign ptr_next  = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

    always_comb begin
        mul_din0 = '0;
        mul_din1 = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_ready[i]) begin
                mul_din0 = req_a[i*A_W +: A_W];
                mul_din1 = req_b[i*B_W +: B_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (issue) begin
            ptr <= ptr_next;
        end
    end

    // The shadow pipeline freezes together with the multiplier whenever mul_ce is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            for (int s = 0; s < MUL_LATENCY; s++) begin
                id_pipe[s] <= '0;
            end
        end else if (mul_ce) begin
            vld_pipe[0] <= issue;
            id_pipe[0]  <= grant_id;
            for (int s = 1; s < MUL_LATENCY; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                id_pipe[s]  <= id_pipe[s-1];
            end
        end
    end

endmodule

// File: tb/tb_kernel_stage0_mul_sched.sv
// Directed bench for kernel_stage0_mul_sched with a behavioural 3-stage ce-enabled multiplier.
module tb_kernel_stage0_mul_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [19:0] req_a;
    logic [55:0] req_b;
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  res_id;
    logic [18:0] res_data;
    logic        mul_ce;
    logic [4:0]  mul_din0;
    logic [13:0] mul_din1;
    logic [18:0] mul_dout;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  valid;
        logic [19:0] a;
        logic [55:0] b;
        logic        rdy;
        logic [3:0]  exp_grant;
        logic        exp_rv;
        logic [1:0]  exp_id;
        logic [18:0] exp_data;
        logic        exp_busy;
        logic [4:0]  exp_din0;
        logic [13:0] exp_din1;
    } vec_t;

    vec_t tbl [18];

    kernel_stage0_mul_sched #(
        .N_REQ(4), .ID_W(2), .A_W(5), .B_W(14), .P_W(19), .MUL_LATENCY(3)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_data(res_data),
        .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1),
        .mul_dout(mul_dout), .busy(busy)
    );

    always #5 clk = ~clk;

    // External multiplier: three ce-enabled registers, data not reset.
    logic [18:0] m0, m1, m2;
    always_ff @(posedge clk) begin
        if (mul_ce) begin
            m0 <= 19'(mul_din0) * 19'(mul_din1);
            m1 <= m0;
            m2 <= m1;
        end
    end
    assign mul_dout = m2;

    function automatic logic [19:0] packA(input logic [4:0] a3, input logic [4:0] a2,
                                          input logic [4:0] a1, input logic [4:0] a0);
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic [55:0] packB(input logic [13:0] b3, input logic [13:0] b2,
                                          input logic [13:0] b1, input logic [13:0] b0);
        return {b3, b2, b1, b0};
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [19:0] a,
                                 input logic [55:0] b, input logic rdy);
        req_valid = valid;
        req_a     = a;
        req_b     = b;
        res_ready = rdy;
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(4'b0000, 20'd0, 56'd0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [1:0] eid;
        int delivered;

        // Single op, then edge operands, then fairness between requesters 0 and 3.
        tbl[0]  = '{4'b0100, packA(0, 31, 0, 0), packB(0, 16383, 0, 0), 1'b1, 4'b0100, 1'b0, 2'd0, 19'd0,      1'b0, 5'd31, 14'd16383};
        tbl[1]  = '{4'b0000, 20'd0, 56'd0,                              1'b1, 4'b0000, 1'b0, 2'd0, 19'd0,      1'b1, 5'd0,  14'd0};
        tbl[2]  = '{4'b0000, 20'd0, 56'd0,                              1'b1, 4'b0000, 1'b0, 2'd0, 19'd0,      1'b1, 5'd0,  14'd0};
        tbl[3]  = '{4'b0000, 20'd0, 56'd0,                              1'b1, 4'b0000, 1'b1, 2'd2, 19'd507873, 1'b1, 5'd0,  14'd0};
        tbl[4]  = '{4'b0001, packA(0, 0, 0, 0), packB(0, 0, 0, 16383),  1'b1, 4'b0001, 1'b0, 2'd0, 19'd0,      1'b0, 5'd0,  14'd16383};
        tbl[5]  = '{4'b0010, packA(0, 0, 31, 0), packB(0, 0, 1, 0),     1'b1, 4'b0010, 1'b0, 2'd0, 19'd0,      1'b1, 5'd31, 14'd1};
        tbl[6]  = '{4'b0000, 20'd0, 56'd0,                              1'b1, 4'b0000, 1'b0, 2'd0, 19'd0,      1'b1, 5'd0,  14'd0};
        tbl[7]  = '{4'b0000, 20'd0, 56'd0,                              1'b1, 4'b0000, 1'b1, 2'd0, 19'd0,      1'b1, 5'd0,  14'd0};
        tbl[8]  = '{4'b0000, 20'd0, 56'd0,                              1'b1, 4'b0000, 1'b1, 2'd1, 19'd31,     1'b1, 5'd0,  14'd0};
        tbl[9]  = '{4'b0000, 20'd0, 56'd0,                              1'b1, 4'b0000, 1'b0, 2'd0, 19'd0,      1'b0, 5'd0,  14'd0};
        tbl[10] = '{4'b1001, packA(3, 0, 0, 2), packB(7, 0, 0, 5),      1'b1, 4'b1000, 1'b0, 2'd0, 19'd0,      1'b0, 5'd3,  14'd7};
        tbl[11] = '{4'b1001, packA(3, 0, 0, 2), packB(7, 0, 0, 5),      1'b1, 4'b0001, 1'b0, 2'd0, 19'd0,      1'b1, 5'd2,  14'd5};
        tbl[12] = '{4'b1001, packA(3, 0, 0, 2), packB(7, 0, 0, 5),      1'b1, 4'b1000, 1'b0, 2'd0, 19'd0,      1'b1, 5'd3,  14'd7};
        tbl[13] = '{4'b1001, packA(3, 0, 0, 2), packB(7, 0, 0, 5),      1'b1, 4'b0001, 1'b1, 2'd3, 19'd21,     1'b1, 5'd2,  14'd5};
        tbl[14] = '{4'b0000, 20'd0, 56'd0,                              1'b1, 4'b0000, 1'b1, 2'd0, 19'd10,     1'b1, 5'd0,  14'd0};
        tbl[15] = '{4'b0000, 20'd0, 56'd0,                              1'b1, 4'b0000, 1'b1, 2'd3, 19'd21,     1'b1, 5'd0,  14'd0};
        tbl[16] = '{4'b0000, 20'd0, 56'd0,                              1'b1, 4'b0000, 1'b1, 2'd0, 19'd10,     1'b1, 5'd0,  14'd0};
        tbl[17] = '{4'b0000, 20'd0, 56'd0,                              1'b1, 4'b0000, 1'b0, 2'd0, 19'd0,      1'b0, 5'd0,  14'd0};

        // Reset state, with all requesters asserting valid.
        reset = 1'b1;
        applyStimulus(4'b1111, 20'd0, 56'd0, 1'b1);
        @(negedge clk);
        #2;
        checkOutput("rst_res_valid", int'(res_valid), 0);
        checkOutput("rst_res_id",    int'(res_id),    0);
        checkOutput("rst_busy",      int'(busy),      0);
        checkOutput("rst_req_ready", int'(req_ready), 0);
        checkOutput("rst_mul_ce",    int'(mul_ce),    1);
        checkOutput("rst_din0",      int'(mul_din0),  0);
        checkOutput("rst_din1",      int'(mul_din1),  0);
        applyStimulus(4'b0000, 20'd0, 56'd0, 1'b1);
        @(negedge clk);
        reset = 1'b0;

        for (int n = 0; n < 18; n++) begin
            applyStimulus(tbl[n].valid, tbl[n].a, tbl[n].b, tbl[n].rdy);
            #2;
            checkOutput($sformatf("tbl%0d_grant", n), int'(req_ready), int'(tbl[n].exp_grant));
            checkOutput($sformatf("tbl%0d_ce", n),    int'(mul_ce),    1);
            checkOutput($sformatf("tbl%0d_rv", n),    int'(res_valid), int'(tbl[n].exp_rv));
            checkOutput($sformatf("tbl%0d_busy", n),  int'(busy),      int'(tbl[n].exp_busy));
            checkOutput($sformatf("tbl%0d_din0", n),  int'(mul_din0),  int'(tbl[n].exp_din0));
            checkOutput($sformatf("tbl%0d_din1", n),  int'(mul_din1),  int'(tbl[n].exp_din1));
            if (tbl[n].exp_rv) begin
                checkOutput($sformatf("tbl%0d_id", n),   int'(res_id),   int'(tbl[n].exp_id));
                checkOutput($sformatf("tbl%0d_data", n), int'(res_data), int'(tbl[n].exp_data));
            end
            @(negedge clk);
        end

        // All four requesters valid: strict rotation, one product per cycle.
        doReset();
        for (int c = 0; c < 12; c++) begin
            applyStimulus((c < 8) ? 4'b1111 : 4'b0000, packA(4, 3, 2, 1),
                          packB(100, 100, 100, 100), 1'b1);
            #2;
            checkOutput($sformatf("rr%0d_grant", c), int'(req_ready), (c < 8) ? (1 << (c % 4)) : 0);
            if (c >= 3 && c < 11) begin
                checkOutput($sformatf("rr%0d_rv", c),   int'(res_valid), 1);
                checkOutput($sformatf("rr%0d_id", c),   int'(res_id),    (c - 3) % 4);
                checkOutput($sformatf("rr%0d_data", c), int'(res_data),  ((c - 3) % 4 + 1) * 100);
            end else begin
                checkOutput($sformatf("rr%0d_rv", c), int'(res_valid), 0);
            end
            @(negedge clk);
        end

        // Back-pressure: three ops in flight, downstream stalls for five cycles.
        doReset();
        delivered = 0;
        for (int c = 0; c < 12; c++) begin
            applyStimulus((c < 8) ? 4'b0111 : 4'b0000, packA(0, 3, 2, 1),
                          packB(0, 1002, 1001, 1000), (c < 3 || c >= 8));
            #2;
            if (c < 3) begin
                checkOutput($sformatf("bp%0d_grant", c), int'(req_ready), 1 << c);
            end else if (c < 8) begin
                checkOutput($sformatf("bp%0d_ce", c),    int'(mul_ce),    0);
                checkOutput($sformatf("bp%0d_grant", c), int'(req_ready), 0);
                checkOutput($sformatf("bp%0d_rv", c),    int'(res_valid), 1);
                checkOutput($sformatf("bp%0d_id", c),    int'(res_id),    0);
                checkOutput($sformatf("bp%0d_data", c),  int'(res_data),  1000);
            end else if (c < 11) begin
                checkOutput($sformatf("bp%0d_rv", c),   int'(res_valid), 1);
                checkOutput($sformatf("bp%0d_id", c),   int'(res_id),    c - 8);
                checkOutput($sformatf("bp%0d_data", c), int'(res_data),  (c - 7) * (1000 + c - 8));
            end else begin
                checkOutput("bp_drained_rv",   int'(res_valid), 0);
                checkOutput("bp_drained_busy", int'(busy),      0);
            end
            if (res_valid && res_ready) delivered++;
            @(negedge clk);
        end
        checkOutput("bp_delivered", delivered, 3);

        // Reset while a product is on the output and another is in flight.
        doReset();
        for (int c = 0; c < 4; c++) begin
            applyStimulus((c < 2) ? 4'b0011 : 4'b0000, packA(0, 0, 5, 4),
                          packB(0, 0, 9, 8), 1'b1);
            #2;
            if (c < 2) checkOutput($sformatf("mr%0d_grant", c), int'(req_ready), 1 << c);
            if (c < 3) @(negedge clk);
        end
        checkOutput("mr_pre_rv",   int'(res_valid), 1);
        checkOutput("mr_pre_busy", int'(busy),      1);
        reset     = 1'b1;
        req_valid = 4'b1111;
        #1;
        checkOutput("mr_async_rv",    int'(res_valid), 0);
        checkOutput("mr_async_busy",  int'(busy),      0);
        checkOutput("mr_async_ready", int'(req_ready), 0);
        checkOutput("mr_async_id",    int'(res_id),    0);
        checkOutput("mr_async_ce",    int'(mul_ce),    1);
        checkOutput("mr_async_din0",  int'(mul_din0),  0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            req_valid = (c == 0) ? 4'b1111 : 4'b0000;
            #2;
            if (c == 0) checkOutput("mr_first_grant", int'(req_ready), 1);
            eid = 2'd0;
            checkOutput($sformatf("mr_post%0d_rv", c), int'(res_valid), (c == 3) ? 1 : 0);
            if (c == 3) begin
                checkOutput("mr_post_id",   int'(res_id),   int'(eid));
                checkOutput("mr_post_data", int'(res_data), 32);
            end
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
